// File: rtl/bsg_link_sdr_stream_checker.sv
// Purpose : checks an SDR-link core-side stream against a per-channel incrementing pattern.
// Latency : received_o / error_o / err_* / timeout_o are registered, updating the cycle after the accepting edge.
// Backpressure: ready_o depends only on state and phase; RUN throttles it via stall_mask_p, ERROR drains with ready_o=1.
//
// Ports:
//   clk_i, reset_n_i      core clock, synchronous active-low reset
//   en_i                  enable checking; low parks the block in IDLE
//   v_i, data_i, ready_o  valid/ready stream input, accept = v_i & ready_o
//   error_o, timeout_o    sticky mismatch / no-progress flags
//   received_o            count of correct words accepted
//   err_data_o, err_expected_o, err_index_o  snapshot of the first mismatch
module bsg_link_sdr_stream_checker #(
    parameter int          num_channels_p  = 8,
    parameter int          channel_width_p = 4,
    parameter logic [7:0]  stall_mask_p    = 8'b0000_0000,
    parameter int          timeout_p       = 1024
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic                                       en_i,
    input  logic                                       v_i,
    input  logic [num_channels_p*channel_width_p-1:0]  data_i,
    output logic                                       ready_o,
    output logic                                       error_o,
    output logic                                       timeout_o,
    output logic [31:0]                                received_o,
    output logic [num_channels_p*channel_width_p-1:0]  err_data_o,
    output logic [num_channels_p*channel_width_p-1:0]  err_expected_o,
    output logic [31:0]                                err_index_o
);

    localparam int width_lp = num_channels_p * channel_width_p;
    // Counter is wide enough to hold timeout_p itself, where it saturates.
    localparam int idle_w_lp = $clog2(timeout_p + 1);
    localparam logic [idle_w_lp-1:0] timeout_lp = idle_w_lp'(timeout_p);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [channel_width_p-1:0]     seq_q, seq_d;
    logic [2:0]                     phase_q, phase_d;
    logic [idle_w_lp-1:0]           idle_q, idle_d;
    logic                           error_q, error_d;
    logic                           timeout_q, timeout_d;
    logic [31:0]                    received_q, received_d;
    logic [width_lp-1:0]            err_data_q, err_data_d;
    logic [width_lp-1:0]            err_expected_q, err_expected_d;
    logic [31:0]                    err_index_q, err_index_d;

    logic [width_lp-1:0]            expected_word;
    logic                           accept;
    logic                           run_accept;
    logic                           match;

    // Channel c carries (seq + c), truncated to the channel width.
    always_comb begin
        expected_word = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            expected_word[c*channel_width_p +: channel_width_p] = seq_q + channel_width_p'(c);
        end
    end

    assign accept     = v_i & ready_o;
    assign run_accept = accept & (state_q == RUN);
    assign match      = (data_i == expected_word);

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a mismatch takes priority over a same-cycle en_i drop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            RUN: begin
                if (run_accept && !match) state_d = ERROR;
                else if (!en_i)           state_d = IDLE;
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ready from state and phase only, never from v_i.
    always_comb begin
        ready_o = 1'b0;
        unique case (state_q)
            RUN:     ready_o = ~stall_mask_p[phase_q];
            ERROR:   ready_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        seq_d          = seq_q;
        received_d     = received_q;
        phase_d        = phase_q;
        error_d        = error_q;
        err_data_d     = err_data_q;
        err_expected_d = err_expected_q;
        err_index_d    = err_index_q;

        if (state_q == RUN) begin
            phase_d = phase_q + 3'd1;
        end

        if (run_accept) begin
            if (match) begin
                seq_d      = seq_q + channel_width_p'(1);
                received_d = received_q + 32'd1;
            end else begin
                // Only reachable once: the block then sits in ERROR until reset.
                error_d        = 1'b1;
                err_data_d     = data_i;
                err_expected_d = expected_word;
                err_index_d    = received_q;
            end
        end

        // Throttled cycles count as idle; anything outside RUN clears the count.
        if (state_q != RUN || accept) begin
            idle_d = '0;
        end else if (idle_q == timeout_lp) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + idle_w_lp'(1);
        end

        timeout_d = timeout_q | (idle_d == timeout_lp);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            seq_q          <= '0;
            phase_q        <= '0;
            idle_q         <= '0;
            error_q        <= 1'b0;
            timeout_q      <= 1'b0;
            received_q     <= '0;
            err_data_q     <= '0;
            err_expected_q <= '0;
            err_index_q    <= '0;
        end else begin
            seq_q          <= seq_d;
            phase_q        <= phase_d;
            idle_q         <= idle_d;
            error_q        <= error_d;
            timeout_q      <= timeout_d;
            received_q     <= received_d;
            err_data_q     <= err_data_d;
            err_expected_q <= err_expected_d;
            err_index_q    <= err_index_d;
        end
    end

    assign error_o        = error_q;
    assign timeout_o      = timeout_q;
    assign received_o     = received_q;
    assign err_data_o     = err_data_q;
    assign err_expected_o = err_expected_q;
    assign err_index_o    = err_index_q;

endmodule
